// File: rtl/dmi_core_to_jtag_sync.sv
`timescale 1ns/1ps
// dmi_core_to_jtag_sync
// Return path of the debug module interface: moves one response (data +
// status) from the core clock domain (clk) to the JTAG DTM domain (tck).
// A clk-side holding register is published by flipping req_tgl. The tck side
// detects the flip through a synchroniser, samples the holding register and
// answers by flipping ack_tgl. ack_tgl is synchronised back into clk to free
// the holding register. Only the two toggles cross domains. The holding
// register stays frozen while a request is outstanding, so tck can sample it
// directly.
module dmi_core_to_jtag_sync #(
    parameter int DATA_W      = 32,
    parameter int STAT_W      = 2,
    parameter int SYNC_STAGES = 2      // flops per toggle synchroniser, >= 2
) (
    // core (clk) domain
    input  logic              clk,
    input  logic              rst_n,
    input  logic              core_rsp_valid,
    input  logic [DATA_W-1:0] core_rsp_data,
    input  logic [STAT_W-1:0] core_rsp_stat,
    output logic              core_busy,
    output logic              core_overrun,
    input  logic              core_ovr_clr,
    // JTAG (tck) domain
    input  logic              tck,
    input  logic              trst_n,
    output logic              jtag_rsp_valid,
    output logic [DATA_W-1:0] jtag_rsp_data,
    output logic [STAT_W-1:0] jtag_rsp_stat,
    input  logic              jtag_rsp_take
);

    // Status code reported when a core reset aborts an in-flight response.
    localparam logic [STAT_W-1:0] STAT_ABORT = {STAT_W{1'b1}};

    // ------------------------------------------------------------------
    // clk domain
    // ------------------------------------------------------------------
    logic [DATA_W-1:0]      hold_data_q, hold_data_d;
    logic [STAT_W-1:0]      hold_stat_q, hold_stat_d;
    logic                   req_tgl_q,   req_tgl_d;
    logic                   overrun_q,   overrun_d;
    logic [SYNC_STAGES-1:0] ack_sync_q;
    logic                   ack_sync;
    logic                   capture;
    logic                   overrun_evt;

    // tck-domain toggle observed by the clk synchroniser
    logic                   ack_tgl_q;

    assign ack_sync    = ack_sync_q[SYNC_STAGES-1];
    assign core_busy   = req_tgl_q ^ ack_sync;
    assign capture     = core_rsp_valid & ~core_busy;
    assign overrun_evt = core_rsp_valid &  core_busy;
    assign core_overrun = overrun_q;

    // Next-state for the holding register, request toggle and sticky overrun.
    always_comb begin
        hold_data_d = hold_data_q;
        hold_stat_d = hold_stat_q;
        req_tgl_d   = req_tgl_q;
        overrun_d   = overrun_q;
        if (capture) begin
            hold_data_d = core_rsp_data;
            hold_stat_d = core_rsp_stat;
            req_tgl_d   = ~req_tgl_q;
        end
        // A fresh overrun in the same cycle as a clear keeps the flag set.
        if (core_ovr_clr) begin
            overrun_d = 1'b0;
        end
        if (overrun_evt) begin
            overrun_d = 1'b1;
        end
    end

    // clk-side state registers. The holding status resets to the abort code:
    // if the core is reset after tck already consumed the pending request,
    // req_tgl falling back to 0 looks like a new request to tck, which then
    // reports data 0 with the reset-abort status. At power-on no request is
    // pending, so this value is never presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_data_q <= '0;
            hold_stat_q <= STAT_ABORT;
            req_tgl_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            hold_data_q <= hold_data_d;
            hold_stat_q <= hold_stat_d;
            req_tgl_q   <= req_tgl_d;
            overrun_q   <= overrun_d;
        end
    end

    // Acknowledge toggle synchroniser into clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_sync_q <= '0;
        end else begin
            ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], ack_tgl_q};
        end
    end

    // ------------------------------------------------------------------
    // tck domain
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] req_sync_q;
    logic                   req_s;
    logic                   req_seen_q, req_seen_d;
    logic                   ack_tgl_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]      rsp_data_q,  rsp_data_d;
    logic [STAT_W-1:0]      rsp_stat_q,  rsp_stat_d;
    logic                   new_req;

    assign req_s   = req_sync_q[SYNC_STAGES-1];
    assign new_req = req_s ^ req_seen_q;

    assign jtag_rsp_valid = rsp_valid_q;
    assign jtag_rsp_data  = rsp_data_q;
    assign jtag_rsp_stat  = rsp_stat_q;

    // Request toggle synchroniser into tck.
    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            req_sync_q <= '0;
        end else begin
            req_sync_q <= {req_sync_q[SYNC_STAGES-2:0], req_tgl_q};
        end
    end

    // Next-state for the DTM-facing response. A new request loads and wins
    // over a simultaneous take; data and status are kept after a take.
    always_comb begin
        req_seen_d  = req_seen_q;
        ack_tgl_d   = ack_tgl_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_stat_d  = rsp_stat_q;
        if (new_req) begin
            // hold_* is frozen until ack_tgl returns to clk, safe to sample.
            rsp_data_d  = hold_data_q;
            rsp_stat_d  = hold_stat_q;
            rsp_valid_d = 1'b1;
            req_seen_d  = req_s;
            ack_tgl_d   = ~ack_tgl_q;
        end else if (jtag_rsp_take) begin
            rsp_valid_d = 1'b0;
        end
    end

    // tck-side state registers.
    always_ff @(posedge tck or negedge trst_n) begin
        if (!trst_n) begin
            req_seen_q  <= 1'b0;
            ack_tgl_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_stat_q  <= '0;
        end else begin
            req_seen_q  <= req_seen_d;
            ack_tgl_q   <= ack_tgl_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_stat_q  <= rsp_stat_d;
        end
    end

endmodule
